// File: rtl/exotiny_pkg.sv
// Shared types and constants for the exotiny memory-port arbiter.
package exotiny_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_e;

  // The instruction bus only ever reads whole words.
  localparam logic [3:0] IMEM_BE = 4'hF;

  // Encoding of the most recently granted master, used for round-robin.
  localparam logic RR_IMEM = 1'b0;
  localparam logic RR_DMEM = 1'b1;

endpackage

// File: rtl/wb_mem_arb_wdog.sv
// Grant watchdog: counts cycles spent in a grant and flags the last allowed one.
// The counter is zeroed on every new grant. It then counts up once per cycle
// while a grant is held. It expires on the cycle whose count equals TOCYC-1,
// which is the TOCYC-th cycle of the grant.
module wb_arb_wdog #(
  parameter int unsigned TOCYC = 1023
) (
  input  logic clk_i,
  input  logic rst_in,
  input  logic clr_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned   CW   = $clog2(TOCYC);
  localparam logic [CW-1:0] LAST = CW'(TOCYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear on a new grant, advance while the grant is held.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = run_i & (cnt_q == LAST);

endmodule

// File: rtl/wb_mem_arb.sv
// Two-master Wishbone arbiter for the shared QSPI memory port (imem + dmem).
// A grant is registered and held until the slave acks or the master abandons.
// This keeps the address and data stable for a whole QSPI transaction.
// Optional build macro WB_ARB_TIMEOUT_EN adds a grant watchdog. When the
// watchdog expires, it aborts the transfer with an ack carrying zero data and
// raises a one-cycle err_o pulse.
//
// state     | meaning
// ----------+-----------------------------------------------
// ARB_IDLE  | no grant, slave port quiet, arbitration point
// ARB_GNT_I | instruction bus owns the slave port
// ARB_GNT_D | data bus owns the slave port
import exotiny_pkg::*;

module wb_mem_arb #(
  parameter string       PRIO  = "RR",
  parameter int unsigned TOCYC = 1023
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        i_stb_i,
  input  logic [31:0] i_adr_i,
  output logic        i_ack_o,
  output logic [31:0] i_dat_o,
  input  logic        d_stb_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_adr_i,
  input  logic [31:0] d_dat_i,
  output logic        d_ack_o,
  output logic [31:0] d_dat_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_be_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_dat_i,
  output logic        err_o
);

  localparam logic PRIO_IMEM = (PRIO == "IMEM");

  if (TOCYC < 2) begin : g_tocyc_chk
    $error("wb_mem_arb: TOCYC must be at least 2");
  end

  arb_state_e state_q, state_d;
  logic       rr_last_q, rr_last_d;
  logic       gnt_i, gnt_d, stb_g, wd_hit, to_abort, new_gnt;

  assign gnt_i = (state_q == ARB_GNT_I);
  assign gnt_d = (state_q == ARB_GNT_D);
  assign stb_g = (gnt_i & i_stb_i) | (gnt_d & d_stb_i);

  // A real ack in the expiry cycle wins over the watchdog abort.
  assign to_abort = wd_hit & stb_g & ~m_ack_i;
  assign new_gnt  = (state_q == ARB_IDLE) & (state_d != ARB_IDLE);

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_wdog #(.TOCYC(TOCYC)) u_wdog (
    .clk_i     (clk_i),
    .rst_in    (rst_in),
    .clr_i     (new_gnt),
    .run_i     (gnt_i | gnt_d),
    .expired_o (wd_hit)
  );
`else
  assign wd_hit = 1'b0;
`endif

  // Arbitration and release: pick a master in IDLE, drop back on ack/abandon/abort.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    case (state_q)
      ARB_IDLE: begin
        if (i_stb_i && (!d_stb_i || PRIO_IMEM || rr_last_q == RR_DMEM)) begin
          state_d   = ARB_GNT_I;
          rr_last_d = RR_IMEM;
        end else if (d_stb_i) begin
          state_d   = ARB_GNT_D;
          rr_last_d = RR_DMEM;
        end
      end
      ARB_GNT_I, ARB_GNT_D: begin
        if (m_ack_i || !stb_g || to_abort) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and round-robin history registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state_q   <= ARB_IDLE;
      rr_last_q <= RR_DMEM;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
    end
  end

  // Slave-side mux: the granted master drives the port, IDLE drives zeros.
  always_comb begin
    m_stb_o = stb_g & ~to_abort;
    m_we_o  = gnt_d & d_we_i;
    m_be_o  = '0;
    m_adr_o = '0;
    m_dat_o = '0;
    if (gnt_i) begin
      m_be_o  = IMEM_BE;
      m_adr_o = i_adr_i;
    end else if (gnt_d) begin
      m_be_o  = d_be_i;
      m_adr_o = d_adr_i;
      m_dat_o = d_dat_i;
    end
  end

  assign i_ack_o = gnt_i & (m_ack_i | to_abort);
  assign d_ack_o = gnt_d & (m_ack_i | to_abort);
  assign i_dat_o = (gnt_i & ~to_abort) ? m_dat_i : 32'h0;
  assign d_dat_o = (gnt_d & ~to_abort) ? m_dat_i : 32'h0;
  assign err_o   = to_abort;

endmodule

// File: tb/tb_wb_mem_arb.sv
// Bench for wb_mem_arb: one round-robin and one imem-priority instance share
// the same stimulus; sel chooses which one is being checked.
module tb_wb_mem_arb;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        i_stb = 1'b0, d_stb = 1'b0, d_we = 1'b0, m_ack = 1'b0;
  logic [31:0] i_adr = '0, d_adr = '0, d_dat = '0, m_dat = '0;
  logic [3:0]  d_be = '0;

  logic        i_ack [2];
  logic        d_ack [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic        err   [2];
  logic [3:0]  m_be  [2];
  logic [31:0] i_dat [2];
  logic [31:0] d_dat_o [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_dat_o [2];

  int sel = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  who;   // {i_ack, d_ack}
    logic [31:0] dat;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  wb_mem_arb #(.PRIO("RR"), .TOCYC(8)) u_rr (
    .clk_i(clk), .rst_in(rst_in),
    .i_stb_i(i_stb), .i_adr_i(i_adr), .i_ack_o(i_ack[0]), .i_dat_o(i_dat[0]),
    .d_stb_i(d_stb), .d_we_i(d_we), .d_be_i(d_be), .d_adr_i(d_adr), .d_dat_i(d_dat),
    .d_ack_o(d_ack[0]), .d_dat_o(d_dat_o[0]),
    .m_stb_o(m_stb[0]), .m_we_o(m_we[0]), .m_be_o(m_be[0]), .m_adr_o(m_adr[0]),
    .m_dat_o(m_dat_o[0]), .m_ack_i(m_ack), .m_dat_i(m_dat), .err_o(err[0])
  );

  wb_mem_arb #(.PRIO("IMEM"), .TOCYC(8)) u_im (
    .clk_i(clk), .rst_in(rst_in),
    .i_stb_i(i_stb), .i_adr_i(i_adr), .i_ack_o(i_ack[1]), .i_dat_o(i_dat[1]),
    .d_stb_i(d_stb), .d_we_i(d_we), .d_be_i(d_be), .d_adr_i(d_adr), .d_dat_i(d_dat),
    .d_ack_o(d_ack[1]), .d_dat_o(d_dat_o[1]),
    .m_stb_o(m_stb[1]), .m_we_o(m_we[1]), .m_be_o(m_be[1]), .m_adr_o(m_adr[1]),
    .m_dat_o(m_dat_o[1]), .m_ack_i(m_ack), .m_dat_i(m_dat), .err_o(err[1])
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic do_reset();
    i_stb = 1'b0; d_stb = 1'b0; d_we = 1'b0; m_ack = 1'b0;
    rst_in = 1'b0;
    cyc();
    cyc();
    rst_in = 1'b1;
  endtask

  // Ack monitor: every ack or err pulse on the selected instance must match the next expectation.
  initial begin
    logic [31:0] act_dat;
    forever begin
      @(negedge clk);
      if (i_ack[sel] === 1'b1 || d_ack[sel] === 1'b1 || err[sel] === 1'b1) begin
        n_vec++;
        act_dat = (i_ack[sel] === 1'b1) ? i_dat[sel] : d_dat_o[sel];
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL ack_unexpected: got i_ack=%b d_ack=%b err=%b dat=%h, expected no ack (t=%0t)",
                   i_ack[sel], d_ack[sel], err[sel], act_dat, $time);
        end else begin
          e = sb.pop_front();
          if ({i_ack[sel], d_ack[sel]} !== e.who || act_dat !== e.dat || err[sel] !== e.err) begin
            n_err++;
            $display("FAIL ack_cmp: got ack=%b dat=%h err=%b, expected ack=%b dat=%h err=%b (t=%0t)",
                     {i_ack[sel], d_ack[sel]}, act_dat, err[sel], e.who, e.dat, e.err, $time);
          end
        end
      end
    end
  end

  initial begin
    // 1. Reset held 3 cycles with both requests and a stray slave ack.
    rst_in = 1'b0; i_stb = 1'b1; d_stb = 1'b1; m_ack = 1'b1; m_dat = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      cyc(); look();
      for (int s = 0; s < 2; s++) begin
        chk("rst_stb", {31'b0, m_stb[s]}, 32'd0);
        chk("rst_iack", {31'b0, i_ack[s]}, 32'd0);
        chk("rst_dack", {31'b0, d_ack[s]}, 32'd0);
        chk("rst_err", {31'b0, err[s]}, 32'd0);
      end
    end
    rst_in = 1'b1; i_stb = 1'b0; d_stb = 1'b0; m_ack = 1'b0;

    // 2. Lone imem read, slave acks on the 4th grant cycle.
    sel = 0;
    cyc(); i_stb = 1'b1; i_adr = 32'h100; look();
    chk("t2_stb_lat", {31'b0, m_stb[0]}, 32'd0);
    cyc(); look();
    chk("t2_stb", {31'b0, m_stb[0]}, 32'd1);
    chk("t2_be", {28'b0, m_be[0]}, 32'hF);
    chk("t2_we", {31'b0, m_we[0]}, 32'd0);
    chk("t2_adr", m_adr[0], 32'h100);
    cyc(); cyc();
    cyc(); m_ack = 1'b1; m_dat = 32'hCAFE_F00D;
    sb.push_back('{who: 2'b10, dat: 32'hCAFE_F00D, err: 1'b0});
    look();
    chk("t2_dack", {31'b0, d_ack[0]}, 32'd0);
    cyc(); m_ack = 1'b0; i_stb = 1'b0; look();
    chk("t2_idle", {31'b0, m_stb[0]}, 32'd0);

    // 3. Round-robin tie: imem first, then dmem write wins the re-request tie.
    do_reset(); sel = 0;
    cyc(); i_stb = 1'b1; i_adr = 32'h10;
    d_stb = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_adr = 32'h1000_0040; d_dat = 32'h1234;
    look();
    chk("t3_stb_lat", {31'b0, m_stb[0]}, 32'd0);
    cyc(); m_ack = 1'b1; m_dat = 32'h1111_1111;
    sb.push_back('{who: 2'b10, dat: 32'h1111_1111, err: 1'b0});
    look();
    chk("t3_i_adr", m_adr[0], 32'h10);
    chk("t3_i_we", {31'b0, m_we[0]}, 32'd0);
    cyc(); m_ack = 1'b0; i_adr = 32'h14; look();
    chk("t3_gap1", {31'b0, m_stb[0]}, 32'd0);
    cyc(); m_ack = 1'b1; m_dat = 32'hDEAD_0001;
    sb.push_back('{who: 2'b01, dat: 32'hDEAD_0001, err: 1'b0});
    look();
    chk("t3_d_stb", {31'b0, m_stb[0]}, 32'd1);
    chk("t3_d_adr", m_adr[0], 32'h1000_0040);
    chk("t3_d_we", {31'b0, m_we[0]}, 32'd1);
    chk("t3_d_be", {28'b0, m_be[0]}, 32'h3);
    chk("t3_d_dat", m_dat_o[0], 32'h1234);
    cyc(); m_ack = 1'b0; d_stb = 1'b0; d_we = 1'b0; look();
    chk("t3_gap2", {31'b0, m_stb[0]}, 32'd0);
    cyc(); m_ack = 1'b1; m_dat = 32'h0BAD_F00D;
    sb.push_back('{who: 2'b10, dat: 32'h0BAD_F00D, err: 1'b0});
    look();
    chk("t3_i2_adr", m_adr[0], 32'h14);
    cyc(); m_ack = 1'b0; i_stb = 1'b0;

    // 4. Fixed imem priority: imem re-requests 3 times, dmem waits until imem idles.
    do_reset(); sel = 1;
    cyc(); i_stb = 1'b1; i_adr = 32'h20;
    d_stb = 1'b1; d_we = 1'b0; d_be = 4'hF; d_adr = 32'h1000_0080;
    for (int k = 0; k < 3; k++) begin
      cyc(); m_ack = 1'b1; m_dat = 32'hA000_0000 + k;
      sb.push_back('{who: 2'b10, dat: 32'hA000_0000 + k, err: 1'b0});
      look();
      chk("t4_i_adr", m_adr[1], 32'h20 + 4 * k);
      chk("t4_i_stb", {31'b0, m_stb[1]}, 32'd1);
      cyc(); m_ack = 1'b0; i_adr = 32'h24 + 4 * k;
      if (k == 2) i_stb = 1'b0;
      look();
      chk("t4_gap", {31'b0, m_stb[1]}, 32'd0);
    end
    cyc(); m_ack = 1'b1; m_dat = 32'hB0B0_0001;
    sb.push_back('{who: 2'b01, dat: 32'hB0B0_0001, err: 1'b0});
    look();
    chk("t4_d_adr", m_adr[1], 32'h1000_0080);
    chk("t4_d_we", {31'b0, m_we[1]}, 32'd0);
    cyc(); m_ack = 1'b0; d_stb = 1'b0;

    // 5. Abandon: dmem drops stb in its 3rd grant cycle, then a late ack arrives.
    do_reset(); sel = 0;
    cyc(); d_stb = 1'b1; d_we = 1'b0; d_adr = 32'h1000_0100;
    cyc(); look();
    chk("t5_g1", {31'b0, m_stb[0]}, 32'd1);
    cyc(); look();
    chk("t5_g2", {31'b0, m_stb[0]}, 32'd1);
    cyc(); d_stb = 1'b0; look();
    chk("t5_drop", {31'b0, m_stb[0]}, 32'd0);
    cyc(); m_ack = 1'b1; m_dat = 32'h7777; look();
    chk("t5_late_dack", {31'b0, d_ack[0]}, 32'd0);
    chk("t5_late_iack", {31'b0, i_ack[0]}, 32'd0);
    chk("t5_idle", {31'b0, m_stb[0]}, 32'd0);
    cyc(); m_ack = 1'b0;

`ifdef WB_ARB_TIMEOUT_EN
    // 6a. Slave never acks: abort with err on the 8th grant cycle.
    do_reset(); sel = 0;
    cyc(); d_stb = 1'b1; d_adr = 32'h1000_0200;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 8) sb.push_back('{who: 2'b01, dat: 32'h0, err: 1'b1});
      look();
      chk("t6_err", {31'b0, err[0]}, (k == 8) ? 32'd1 : 32'd0);
      chk("t6_stb", {31'b0, m_stb[0]}, (k == 8) ? 32'd0 : 32'd1);
    end
    cyc(); d_stb = 1'b0; look();
    chk("t6_idle", {31'b0, m_stb[0]}, 32'd0);
    chk("t6_err_off", {31'b0, err[0]}, 32'd0);
    // 6b. Ack arrives in the expiry cycle: normal ack, no err.
    cyc(); d_stb = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 8) begin
        m_ack = 1'b1; m_dat = 32'h5A5A_5A5A;
        sb.push_back('{who: 2'b01, dat: 32'h5A5A_5A5A, err: 1'b0});
      end
      look();
      chk("t6b_err", {31'b0, err[0]}, 32'd0);
      chk("t6b_stb", {31'b0, m_stb[0]}, 32'd1);
    end
    cyc(); m_ack = 1'b0; d_stb = 1'b0;
`else
    // 6. Without the watchdog the grant is held indefinitely and err_o stays low.
    do_reset(); sel = 0;
    cyc(); d_stb = 1'b1; d_adr = 32'h1000_0200;
    for (int k = 1; k <= 12; k++) begin
      cyc(); look();
      chk("t6_hold_stb", {31'b0, m_stb[0]}, 32'd1);
      chk("t6_hold_err", {31'b0, err[0]}, 32'd0);
    end
    cyc(); d_stb = 1'b0;
`endif

    cyc(); cyc();
    while (sb.size() > 0) begin
      exp_t m;
      m = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL ack_missing: got no ack, expected ack=%b dat=%h err=%b", m.who, m.dat, m.err);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
